vga_pattern_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_timing.sv | 75 +++++++
 rtl/vga_pattern_gen.sv | 217 +++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, pattern mode encodings, 3-bit colour table.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // {R,G,B}; index order: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][2:0] COLOR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel tick generator, h/v position counters and raw (active-high) sync/active flags.
module vga_timing #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HW       = 10,
    parameter int unsigned VW       = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          tick_o,
    output logic          h_last_o,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          active_o
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned TW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    assign tick_o   = (tick_cnt_q == TICK_LAST);
    assign h_last_o = (h_cnt_q == H_LAST);
    assign h_cnt_o  = h_cnt_q;
    assign v_cnt_o  = v_cnt_q;
    assign hsync_o  = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    assign vsync_o  = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    assign active_o = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    always_comb begin
        tick_cnt_d = tick_o ? '0 : tick_cnt_q + 1'b1;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        if (tick_o) begin
            h_cnt_d = h_last_o ? '0 : h_cnt_q + 1'b1;
            if (h_last_o) begin
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing + four test patterns stepped by a button; one registered output stage on pixel tick.
// Optional VGA_BORDER_EN forces a white one-pixel frame around the active area.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned COLOR_W    = 4,
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int unsigned CHECK_LOG2 = 5,
    parameter int unsigned SOLID_HOLD = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_step,
    output logic               Hsync,
    output logic               Vsync,
    output logic [COLOR_W-1:0] vgaRed,
    output logic [COLOR_W-1:0] vgaGreen,
    output logic [COLOR_W-1:0] vgaBlue,
    output logic               blanking,
    output logic               frame_start,
    output logic [1:0]         mode
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are widened so the gradient and checker bit selects always exist.
    localparam int unsigned HW = max_u(max_u($clog2(H_TOTAL), COLOR_W + 2), CHECK_LOG2 + 1);
    localparam int unsigned VW = max_u($clog2(V_TOTAL), CHECK_LOG2 + 1);
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned BW = $clog2(BAR_W) + 1;
    localparam int unsigned SW = $clog2(SOLID_HOLD) + 1;

    logic          tick, h_last, hs_raw, vs_raw, active;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_ACTIVE(V_ACTIVE),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP),
        .HW      (HW),
        .VW      (VW)
    ) u_timing (
        .clk_i   (clk),
        .rst_i   (rst),
        .tick_o  (tick),
        .h_last_o(h_last),
        .h_cnt_o (h_cnt),
        .v_cnt_o (v_cnt),
        .hsync_o (hs_raw),
        .vsync_o (vs_raw),
        .active_o(active)
    );

    mode_e              mode_q, mode_d;
    logic               pending_q, pending_d;
    logic               mode_step_q;
    logic [SW-1:0]      solid_cnt_q, solid_cnt_d;
    logic [2:0]         solid_idx_q, solid_idx_d;
    logic [BW-1:0]      bar_px_q, bar_px_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic               hsync_q, vsync_q, blank_q, frame_start_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q, red_d, green_d, blue_d;
    logic               step_edge, frame_tick, apply, on_border;
    logic [2:0]         bar_rgb, solid_rgb;

    assign step_edge  = mode_step & ~mode_step_q;
    assign frame_tick = tick && (h_cnt == '0) && (v_cnt == '0);
    assign apply      = frame_tick & pending_q;
    assign bar_rgb    = COLOR_TABLE[bar_idx_q];
    assign solid_rgb  = COLOR_TABLE[solid_idx_d];

`ifdef VGA_BORDER_EN
    assign on_border = (h_cnt == '0) || (h_cnt == HW'(H_ACTIVE - 1)) ||
                       (v_cnt == '0) || (v_cnt == VW'(V_ACTIVE - 1));
`else
    assign on_border = 1'b0;
`endif

    // Mode stepping, solid-colour sequencing and the bar position tracker.
    always_comb begin
        mode_d      = mode_q;
        pending_d   = pending_q | step_edge;
        solid_cnt_d = solid_cnt_q;
        solid_idx_d = solid_idx_q;
        bar_px_d    = bar_px_q;
        bar_idx_d   = bar_idx_q;
        if (apply) begin
            mode_d    = mode_e'(mode_q + 2'd1);
            pending_d = step_edge;
        end
        if (apply && (mode_d == MODE_SOLID)) begin
            solid_cnt_d = '0;
            solid_idx_d = '0;
        end else if (frame_tick && (mode_q == MODE_SOLID)) begin
            if (solid_cnt_q == SW'(SOLID_HOLD - 1)) begin
                solid_cnt_d = '0;
                solid_idx_d = solid_idx_q + 3'd1;
            end else begin
                solid_cnt_d = solid_cnt_q + 1'b1;
            end
        end
        if (tick) begin
            if (h_last) begin
                bar_px_d  = '0;
                bar_idx_d = '0;
            end else if (bar_px_q == BW'(BAR_W - 1)) begin
                bar_px_d = '0;
                if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d = bar_px_q + 1'b1;
            end
        end
    end

    // Pattern uses mode_d so a newly applied mode covers its whole first frame.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        unique case (mode_d)
            MODE_BARS: begin
                red_d   = {COLOR_W{bar_rgb[2]}};
                green_d = {COLOR_W{bar_rgb[1]}};
                blue_d  = {COLOR_W{bar_rgb[0]}};
            end
            MODE_CHECK: begin
                if (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) begin
                    red_d   = '1;
                    green_d = '1;
                    blue_d  = '1;
                end
            end
            MODE_GRAD: begin
                red_d   = h_cnt[COLOR_W+1:2];
                green_d = h_cnt[COLOR_W+1:2];
                blue_d  = h_cnt[COLOR_W+1:2];
            end
            MODE_SOLID: begin
                red_d   = {COLOR_W{solid_rgb[2]}};
                green_d = {COLOR_W{solid_rgb[1]}};
                blue_d  = {COLOR_W{solid_rgb[0]}};
            end
            default: ;
        endcase
        if (on_border) begin
            red_d   = '1;
            green_d = '1;
            blue_d  = '1;
        end
        if (!active) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= MODE_BARS;
            pending_q     <= 1'b0;
            mode_step_q   <= 1'b0;
            solid_cnt_q   <= '0;
            solid_idx_q   <= '0;
            bar_px_q      <= '0;
            bar_idx_q     <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            mode_q        <= mode_d;
            pending_q     <= pending_d;
            mode_step_q   <= mode_step;
            solid_cnt_q   <= solid_cnt_d;
            solid_idx_q   <= solid_idx_d;
            bar_px_q      <= bar_px_d;
            bar_idx_q     <= bar_idx_d;
            frame_start_q <= frame_tick;
            if (tick) begin
                hsync_q <= hs_raw ? SYNC_POL : ~SYNC_POL;
                vsync_q <= vs_raw ? SYNC_POL : ~SYNC_POL;
                blank_q <= ~active;
                red_q   <= red_d;
                green_q <= green_d;
                blue_q  <= blue_d;
            end
        end
    end

    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign blanking    = blank_q;
    assign frame_start = frame_start_q;
    assign vgaRed      = red_q;
    assign vgaGreen    = green_q;
    assign vgaBlue     = blue_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a shrunken 32x8 raster (40x13 total, 2 clk per pixel).
module tb_vga_pattern_gen;
    localparam int CD    = 2;
    localparam int HT    = 40;
    localparam int VT    = 13;
    localparam int FRAME = HT * VT * CD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_step = 1'b0;
    logic       Hsync, Vsync, blanking, frame_start;
    logic [3:0] vgaRed, vgaGreen, vgaBlue;
    logic [1:0] mode;

    vga_pattern_gen #(
        .CLK_DIV(CD), .COLOR_W(4),
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .CHECK_LOG2(2), .SOLID_HOLD(2)
    ) dut (
        .clk(clk), .rst(rst), .mode_step(mode_step),
        .Hsync(Hsync), .Vsync(Vsync),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .blanking(blanking), .frame_start(frame_start), .mode(mode)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // exp = {frame_start, mode, blanking, Hsync, Vsync, R, G, B}
    typedef struct {
        int unsigned at;
        string       name;
        logic [17:0] exp;
    } vec_t;

    vec_t        sb[$];
    vec_t        cur;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned fs_cyc = 0;
    int unsigned fs_count = 0;
    logic [17:0] act;

    function automatic logic [11:0] brd(input logic [11:0] c);
`ifdef VGA_BORDER_EN
        return 12'hFFF;
`else
        return c;
`endif
    endfunction

    task automatic push(input int unsigned at, input string name, input logic fs,
                        input logic [1:0] m, input logic bl, input logic hs, input logic vs,
                        input logic [11:0] rgb);
        vec_t v;
        v.at   = at;
        v.name = name;
        v.exp  = {fs, m, bl, hs, vs, rgb};
        sb.push_back(v);
    endtask

    // Active pixel: frame_start only at (0,0), syncs idle.
    task automatic act_px(input int unsigned base, input int h, input int v, input string name,
                          input logic [1:0] m, input logic [11:0] rgb);
        push(base + int'((v * HT + h) * CD), name, (h == 0 && v == 0), m, 1'b0, 1'b1, 1'b1, rgb);
    endtask

    task automatic blk_px(input int unsigned base, input int h, input int v, input string name,
                          input logic [1:0] m, input logic hs, input logic vs);
        push(base + int'((v * HT + h) * CD), name, 1'b0, m, 1'b1, hs, vs, 12'h000);
    endtask

    task automatic wait_fs();
        int unsigned start;
        start = fs_count;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(posedge clk);
            if (fs_count > start) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL frame_wait: no frame_start within %0d clk, needed one", 3 * FRAME);
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (frame_start) begin
            fs_cyc = cyc;
            fs_count++;
        end
        act = {frame_start, mode, blanking, Hsync, Vsync, vgaRed, vgaGreen, vgaBlue};
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            vectors++;
            if (cur.at != cyc) begin
                miscompares++;
                $display("FAIL %s: sample slot %0d missed (now %0d)", cur.name, cur.at, cyc);
            end else if (act !== cur.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h (fs,mode,blank,hs,vs,rgb)",
                         cur.name, act, cur.exp);
            end
        end
    end

    int unsigned a, b, c, d, e, g;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        push(cyc, "reset_state", 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 12'h000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(cyc + 2, "first_frame_start", 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 12'hFFF);
        wait_fs();

        a = fs_cyc + FRAME;
        b = a + FRAME;
        c = b + FRAME;
        d = c + FRAME;
        e = d + FRAME;
        g = e + FRAME;

        // Frame A: colour bars, sync windows
        act_px(a, 0, 0, "bars_0_0", 2'd0, 12'hFFF);
        act_px(a, 3, 2, "bar0_end", 2'd0, 12'hFFF);
        act_px(a, 4, 2, "bar1_yellow", 2'd0, 12'hFF0);
        act_px(a, 8, 2, "bar2_cyan", 2'd0, 12'h0FF);
        act_px(a, 12, 2, "bar3_green", 2'd0, 12'h0F0);
        act_px(a, 16, 2, "bar4_magenta", 2'd0, 12'hF0F);
        act_px(a, 20, 2, "bar5_red", 2'd0, 12'hF00);
        act_px(a, 24, 2, "bar6_blue", 2'd0, 12'h00F);
        act_px(a, 30, 2, "bar7_black", 2'd0, 12'h000);
        blk_px(a, 32, 2, "h_first_blank", 2'd0, 1'b1, 1'b1);
        blk_px(a, 34, 2, "hsync_first", 2'd0, 1'b0, 1'b1);
        blk_px(a, 37, 2, "hsync_last", 2'd0, 1'b0, 1'b1);
        blk_px(a, 38, 2, "hsync_after", 2'd0, 1'b1, 1'b1);
        act_px(a, 0, 7, "mode_held_mid", 2'd0, 12'hFFF);
        blk_px(a, 0, 8, "v_first_blank", 2'd0, 1'b1, 1'b1);
        blk_px(a, 0, 9, "vsync_first", 2'd0, 1'b1, 1'b0);
        blk_px(a, 5, 10, "vsync_last", 2'd0, 1'b1, 1'b0);
        blk_px(a, 0, 11, "vsync_after", 2'd0, 1'b1, 1'b1);
        // Frame B: checkerboard after three pulses in A
        act_px(b, 0, 0, "chk_0_0", 2'd1, brd(12'h000));
        act_px(b, 1, 0, "chk_top_edge", 2'd1, brd(12'h000));
        act_px(b, 4, 0, "chk_4_0", 2'd1, 12'hFFF);
        act_px(b, 0, 1, "chk_left_edge", 2'd1, brd(12'h000));
        blk_px(b, 35, 1, "chk_hsync", 2'd1, 1'b0, 1'b1);
        act_px(b, 0, 4, "chk_0_4", 2'd1, 12'hFFF);
        act_px(b, 4, 4, "chk_4_4", 2'd1, 12'h000);
        act_px(b, 31, 4, "chk_right_edge", 2'd1, brd(12'h000));
        act_px(b, 5, 7, "chk_bottom_edge", 2'd1, brd(12'h000));
        // Frames C..E: gradient, mode_step held high throughout
        act_px(c, 0, 0, "grad_enter", 2'd2, brd(12'h000));
        act_px(d, 10, 1, "grad_held1", 2'd2, 12'h222);
        act_px(e, 0, 0, "grad_held2", 2'd2, brd(12'h000));
        act_px(e, 4, 1, "grad_4", 2'd2, 12'h111);
        act_px(e, 30, 3, "grad_30", 2'd2, 12'h777);
        // Frames G..G+4: solid colour, two frames per colour
        act_px(g, 0, 0, "solid_white0", 2'd3, 12'hFFF);
        blk_px(g, 33, 0, "solid_blank", 2'd3, 1'b1, 1'b1);
        act_px(g + FRAME, 7, 7, "solid_white1", 2'd3, 12'hFFF);
        act_px(g + 2 * FRAME, 0, 0, "solid_yellow0", 2'd3, brd(12'hFF0));
        act_px(g + 2 * FRAME, 20, 5, "solid_yellow0b", 2'd3, 12'hFF0);
        act_px(g + 3 * FRAME, 20, 5, "solid_yellow1", 2'd3, 12'hFF0);
        act_px(g + 4 * FRAME, 0, 0, "solid_cyan0", 2'd3, brd(12'h0FF));
        act_px(g + 4 * FRAME, 8, 3, "solid_cyan0b", 2'd3, 12'h0FF);

        wait_until(a + 600);
        repeat (3) begin
            mode_step = 1'b1;
            @(posedge clk);
            #1;
            mode_step = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        wait_until(b + 700);
        mode_step = 1'b1;
        wait_until(e + 400);
        mode_step = 1'b0;
        wait_until(e + 500);
        mode_step = 1'b1;
        wait_until(e + 504);
        mode_step = 1'b0;

        // Pending request then reset mid-frame at about (20,5)
        wait_until(g + 5 * FRAME + 100);
        mode_step = 1'b1;
        @(posedge clk);
        #1;
        mode_step = 1'b0;
        wait_until(g + 5 * FRAME + 440);
        rst = 1'b1;
        @(posedge clk);
        #1;
        push(cyc, "reset_mid_frame", 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 12'h000);
        rst = 1'b0;
        push(cyc + 2, "post_reset_frame", 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 12'hFFF);
        push(cyc + 2 + 44 * CD, "post_reset_bar1", 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 12'hFF0);

        for (int i = 0; i < 3 * FRAME && sb.size() > 0; i++) @(posedge clk);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: never sampled, expected %h at %0d", cur.name, cur.exp, cur.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
